// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute over a shared ALU
// and a single memory port with a ready handshake, traps illegal opcodes, counts retirements.
module multicycle_control #(
  parameter int CNT_W     = 32,
  parameter bit TRAP_HALT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2, S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEX   = 4'd6, S_RTWB  = 4'd7,
    S_BEQ    = 4'd8,  S_JMP    = 4'd9,  S_IMMEX  = 4'd10, S_IMMWB = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  state_e             state_q, state_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               retire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR/PC load only in the cycle the memory actually returns the word
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:                                 state_d = S_RTEX;
          OP_LW, OP_SW:                             state_d = S_MEMADR;
          OP_BEQ:                                   state_d = S_BEQ;
          OP_J:                                     state_d = S_JMP;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state_d = S_IMMEX;
          default:                                  state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_RTEX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_RTWB;
      end
      S_RTWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_d       = S_FETCH;
      end
      S_JMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = S_FETCH;
      end
      S_IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (opcode == OP_ADDI) ? 2'b00 : 2'b11;
        state_d   = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP: begin
        if (!TRAP_HALT) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Only completed instructions retire; trap exits back to FETCH do not count
  assign retire = (state_d == S_FETCH) &&
                  (state_q inside {S_MEMWB, S_MEMWR, S_RTWB, S_BEQ, S_JMP, S_IMMWB});

  assign illegal_d = illegal_q | (state_d == S_TRAP);
  assign retired_d = retire ? retired_q + 1'b1 : retired_q;

  assign state      = state_q;
  assign illegal_op = illegal_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a halting 32-bit-counter instance and a skipping 4-bit-counter
// instance run the same instruction stream against a per-instruction-class reference model.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;

  logic pw_a, pwc_a, iord_a, mr_a, mw_a, irw_a, m2r_a, rd_a, rw_a, asa_a, ill_a;
  logic [1:0] asb_a, aop_a, pcs_a;
  logic [3:0] st_a;
  logic [31:0] ret_a;
  logic pw_b, pwc_b, iord_b, mr_b, mw_b, irw_b, m2r_b, rd_b, rw_b, asa_b, ill_b;
  logic [1:0] asb_b, aop_b, pcs_b;
  logic [3:0] st_b;
  logic [3:0] ret_b;

  int checks = 0;
  int failures = 0;
  int ret_m_a, ret_m_b;
  bit il_m;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(32), .TRAP_HALT(1'b1)) dut_a (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pw_a), .pc_write_cond(pwc_a), .iord(iord_a), .mem_read(mr_a),
    .mem_write(mw_a), .ir_write(irw_a), .mem_to_reg(m2r_a), .reg_dst(rd_a),
    .reg_write(rw_a), .alu_src_a(asa_a), .alu_src_b(asb_a), .alu_op(aop_a),
    .pc_source(pcs_a), .state(st_a), .illegal_op(ill_a), .retired(ret_a));

  multicycle_control #(.CNT_W(4), .TRAP_HALT(1'b0)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pw_b), .pc_write_cond(pwc_b), .iord(iord_b), .mem_read(mr_b),
    .mem_write(mw_b), .ir_write(irw_b), .mem_to_reg(m2r_b), .reg_dst(rd_b),
    .reg_write(rw_b), .alu_src_a(asa_b), .alu_src_b(asb_b), .alu_op(aop_b),
    .pc_source(pcs_b), .state(st_b), .illegal_op(ill_b), .retired(ret_b));

  // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
  //  reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
  wire [15:0] ctl_a = {pw_a, pwc_a, iord_a, mr_a, mw_a, irw_a, m2r_a, rd_a, rw_a, asa_a,
                       asb_a, aop_a, pcs_a};
  wire [15:0] ctl_b = {pw_b, pwc_b, iord_b, mr_b, mw_b, irw_b, m2r_b, rd_b, rw_b, asa_b,
                       asb_b, aop_b, pcs_b};

  logic [5:0] legal_ops [10] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                                 6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110};

  function automatic logic [15:0] ctl(int st, bit rdy, logic [5:0] op);
    logic [15:0] v;
    v = '0;
    case (st)
      0:  begin v[12] = 1'b1; v[5:4] = 2'b01; v[15] = rdy; v[10] = rdy; end
      1:  v[5:4] = 2'b11;
      2:  begin v[6] = 1'b1; v[5:4] = 2'b10; end
      3:  begin v[13] = 1'b1; v[12] = 1'b1; end
      4:  begin v[7] = 1'b1; v[9] = 1'b1; end
      5:  begin v[13] = 1'b1; v[11] = 1'b1; end
      6:  begin v[6] = 1'b1; v[3:2] = 2'b10; end
      7:  begin v[8] = 1'b1; v[7] = 1'b1; end
      8:  begin v[6] = 1'b1; v[3:2] = 2'b01; v[14] = 1'b1; v[1:0] = 2'b01; end
      9:  begin v[15] = 1'b1; v[1:0] = 2'b10; end
      10: begin v[6] = 1'b1; v[5:4] = 2'b10; v[3:2] = (op == 6'b001000) ? 2'b00 : 2'b11; end
      11: v[7] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_b(int st, bit rdy, logic [5:0] op);
    chk("b.state", {28'd0, st_b}, st);
    chk("b.ctl", {16'd0, ctl_b}, {16'd0, ctl(st, rdy, op)});
    chk("b.illegal", {31'd0, ill_b}, {31'd0, il_m});
    chk("b.retired", {28'd0, ret_b}, ret_m_b % 16);
  endtask

  task automatic chk_a(int st, bit rdy, logic [5:0] op);
    chk("a.state", {28'd0, st_a}, st);
    chk("a.ctl", {16'd0, ctl_a}, {16'd0, ctl(st, rdy, op)});
    chk("a.illegal", {31'd0, ill_a}, {31'd0, il_m});
    chk("a.retired", ret_a, ret_m_a);
  endtask

  // One whole instruction from its FETCH cycle onward. When live_a is 0 the halting
  // instance is expected to sit in TRAP with every strobe low.
  task automatic run_instr(logic [5:0] op, int fw, int mw, bit live_a);
    int sts[$];
    bit rdys[$];
    bit retires;
    retires = 1'b1;
    for (int i = 0; i < fw; i++) begin sts.push_back(0); rdys.push_back(1'b0); end
    sts.push_back(0); rdys.push_back(1'b1);
    sts.push_back(1); rdys.push_back(1'($urandom));
    case (op)
      6'b000000: begin sts.push_back(6); sts.push_back(7); end
      6'b100011: begin
        sts.push_back(2);
        for (int i = 0; i < mw; i++) sts.push_back(3);
        sts.push_back(3); sts.push_back(4);
      end
      6'b101011: begin
        sts.push_back(2);
        for (int i = 0; i < mw; i++) sts.push_back(5);
        sts.push_back(5);
      end
      6'b000100: sts.push_back(8);
      6'b000010: sts.push_back(9);
      6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110: begin
        sts.push_back(10); sts.push_back(11);
      end
      default: begin sts.push_back(12); retires = 1'b0; end
    endcase
    // handshake states get 0 while waiting and 1 on the last cycle; others get noise
    for (int i = rdys.size(); i < sts.size(); i++) begin
      if ((sts[i] == 3 || sts[i] == 5) && (i + 1 < sts.size()) && sts[i+1] == sts[i])
        rdys.push_back(1'b0);
      else if (sts[i] == 3 || sts[i] == 5)
        rdys.push_back(1'b1);
      else
        rdys.push_back(1'($urandom));
    end
    for (int i = 0; i < sts.size(); i++) begin
      @(negedge clk);
      opcode = op;
      mem_ready = rdys[i];
      #1;
      if (sts[i] == 12) il_m = 1'b1;
      chk_b(sts[i], rdys[i], op);
      if (live_a) chk_a(sts[i], rdys[i], op);
      else begin
        chk("a.halt_state", {28'd0, st_a}, 32'd12);
        chk("a.halt_ctl", {16'd0, ctl_a}, 32'd0);
        chk("a.halt_ill", {31'd0, ill_a}, 32'd1);
        chk("a.halt_ret", ret_a, ret_m_a);
      end
    end
    if (retires) begin
      ret_m_b++;
      if (live_a) ret_m_a++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    opcode = 6'd0;
    ret_m_a = 0; ret_m_b = 0; il_m = 1'b0;
    #3;
    chk_a(0, 1'b0, 6'd0);
    chk_b(0, 1'b0, 6'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();

    run_instr(6'b000000, 0, 0, 1'b1);   // R-type, zero-wait
    run_instr(6'b100011, 0, 2, 1'b1);   // lw with two MEMRD wait cycles
    run_instr(6'b000000, 3, 0, 1'b1);   // fetch stalled three cycles
    run_instr(6'b000100, 0, 0, 1'b1);
    run_instr(6'b000010, 0, 0, 1'b1);
    run_instr(6'b001101, 0, 0, 1'b1);
    run_instr(6'b001000, 1, 0, 1'b1);
    run_instr(6'b101011, 0, 1, 1'b1);
    for (int n = 0; n < 20; n++)
      run_instr(legal_ops[$urandom_range(0, 9)], $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);

    // Async reset while a store is waiting in MEMWR
    @(negedge clk); opcode = 6'b101011; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); mem_ready = 1'b0;
    #1;
    chk("pre_rst.state", {28'd0, st_a}, 32'd5);
    chk("pre_rst.mem_write", {31'd0, mw_b}, 32'd1);
    #2 reset = 1'b1;
    #1;
    ret_m_a = 0; ret_m_b = 0; il_m = 1'b0;
    chk_a(0, 1'b0, 6'b101011);
    chk_b(0, 1'b0, 6'b101011);
    @(negedge clk); reset = 1'b0;

    // 16 retirements wrap the 4-bit counter
    for (int n = 0; n < 16; n++)
      run_instr(legal_ops[$urandom_range(0, 9)], $urandom_range(0, 1), $urandom_range(0, 1), 1'b1);
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("wrap.ret_b", {28'd0, ret_b}, 32'd0);
    chk("wrap.ret_a", ret_a, 32'd16);

    // Illegal opcode: instance a halts, instance b skips and carries on
    run_instr(6'b111111, 0, 0, 1'b1);
    run_instr(6'b000000, 0, 0, 1'b0);
    run_instr(6'b100011, 1, 1, 1'b0);
    run_instr(6'b010101, 0, 0, 1'b0);
    run_instr(6'b000010, 0, 0, 1'b0);
    @(negedge clk); #1;
    chk("trap.ill_b", {31'd0, ill_b}, 32'd1);
    chk("trap.state_a", {28'd0, st_a}, 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle main decoder.
- A Moore-style FSM sequences each MIPS instruction over 3–5 cycles and shares one ALU and one unified memory port.
- Memory accesses use a ready handshake.
- Adds illegal-opcode trapping and a retired-instruction counter.
- Sits between the instruction register (opcode source) and the multi-cycle datapath muxes, register file and memory interface.

Parameters:
CNT_W, 32, width of the retired-instruction counter
TRAP_HALT, 1, 1 = FSM halts in TRAP on illegal opcode; 0 = instruction skipped, fetch resumes

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
opcode  input  6  IR[31:26]; must be stable from DECODE until the instruction finishes
mem_ready  input  1  memory completes the current access this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero (datapath ANDs with zero)
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  IR load
mem_to_reg  output  1  write-back select: 1 = MDR
reg_dst  output  1  destination select: 1 = rd, 0 = rt
reg_write  output  1  register-file write enable
alu_src_a  output  1  0 = PC, 1 = A
alu_src_b  output  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
alu_op  output  2  00 = add, 01 = sub, 10 = funct, 11 = imm-op decode
pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
state  output  4  current state code (debug)
illegal_op  output  1  sticky illegal-opcode flag
retired  output  CNT_W  retired-instruction count

Behaviour:
- Clock and reset: one clock domain; reset asynchronous, active-high.
- Reset value: state = FETCH, illegal_op = 0, retired = 0.
- Unlisted control outputs are 0 in every state, including reset. Only the FETCH outputs are active directly after reset.
- Reset mid-operation aborts the instruction immediately. No partial write strobes are generated after reset asserts.
- State codes:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - RTEX=6, RTWB=7, BEQ=8, JMP=9, IMMEX=10, IMMWB=11, TRAP=12
  - Codes 13–15 go to FETCH on the next clock.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - Holds while mem_ready=0.
  - In the mem_ready=1 cycle, ir_write=1 and pc_write=1 (gated by mem_ready), then -> DECODE.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
  - Next state by opcode:
    - 000000 -> RTEX
    - 100011, 101011 -> MEMADR
    - 000100 -> BEQ
    - 000010 -> JMP
    - 001000, 001010, 001100, 001101, 001110 -> IMMEX
    - all others -> TRAP
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: iord=1, mem_read=1. Holds until mem_ready=1, then -> MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, then -> FETCH.
- MEMWR:
  - iord=1, mem_write=1; both stay asserted while waiting.
  - mem_ready=1 -> FETCH.
- RTEX: alu_src_a=1, alu_src_b=00, alu_op=10, then -> RTWB.
- RTWB: reg_dst=1, reg_write=1, then -> FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, then -> FETCH.
- JMP: pc_write=1, pc_source=10, then -> FETCH.
- IMMEX: alu_src_a=1, alu_src_b=10, then -> IMMWB.
  - alu_op=00 for addi (001000).
  - alu_op=11 for slti/andi/ori/xori.
- IMMWB: reg_dst=0, reg_write=1, then -> FETCH.
- TRAP:
  - illegal_op set on entry and sticky until reset.
  - TRAP_HALT=1: remain in TRAP with all strobes 0.
  - TRAP_HALT=0: one cycle in TRAP, then -> FETCH; the PC has already advanced, so the instruction is skipped.
- Retired counter:
  - Increments by 1 on each transition into FETCH from MEMWB, MEMWR, RTWB, BEQ, JMP or IMMWB.
  - Trap exits are not counted.
  - Wraps modulo 2^CNT_W.
- Cycle counts with zero-wait memory:
  - R-type 4, addi/logic-imm 4, beq 3, j 3, lw 5, sw 4.
  - Each mem_ready=0 cycle adds one cycle.
- Outputs are combinational from state; only the FETCH ir_write/pc_write strobes also depend on mem_ready.
- No glitch-sensitive consumers are assumed.

Test Plan:
- Reset then R-type opcode 000000, mem_ready held 1:
  - States 0,1,6,7,0.
  - RTWB shows reg_dst=1, reg_write=1, alu_op=10 in RTEX.
  - retired=1.
- lw (100011) with mem_ready=0 for 2 cycles in MEMRD:
  - mem_read=1, iord=1 held 3 cycles.
  - MEMWB asserts mem_to_reg=1, reg_write=1.
  - 7 total cycles; retired increments once.
- FETCH with mem_ready low 3 cycles:
  - ir_write/pc_write stay 0 until the ready cycle, then pulse exactly 1 cycle.
- beq (000100) and j (000010):
  - BEQ: pc_write_cond=1, pc_source=01, alu_op=01.
  - JMP: pc_write=1, pc_source=10.
  - 3 cycles each.
- ori (001101) vs addi (001000):
  - IMMEX alu_op=11 vs 00.
  - IMMWB reg_write=1, reg_dst=0.
- Opcode 111111:
  - TRAP_HALT=1: illegal_op=1, stays in state 12, retired unchanged.
  - TRAP_HALT=0: returns to FETCH next cycle, illegal_op stays 1.
  - Async reset mid-MEMWR clears to FETCH with mem_write=0 immediately.
  - With CNT_W=4, after 16 retirements retired wraps to 0.
